jtag_tap: RTL
=============

JTAG_TAP -- requirements
Module: jtag_tap

Parameters
REQ-001 SHALL have parameter IR_W, default 4, instruction register width (min 2).
REQ-002 SHALL have parameter IDCODE, default 32'h1000_0001, 32-bit device ID; bit 0 SHALL be 1.

Interface
REQ-003 tck  input  1  test clock; all state changes on posedge tck.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 tms_i  input  1  test mode select, sampled on posedge tck.
REQ-006 tdi_i  input  1  test data in.
REQ-007 tdo_o  output  1  test data out.
REQ-008 tdo_en_o  output  1  high only in SHIFT_DR / SHIFT_IR.
REQ-009 bsr_scan_o  output  1  serial data into boundary chain; equals tdi_i.
REQ-010 bsr_scan_i  input  1  serial data out of last boundary cell.
REQ-011 bsr_shift_o  output  1  boundary shift-DR control.
REQ-012 bsr_capture_o  output  1  boundary first-stage load enable.
REQ-013 bsr_update_o  output  1  boundary update-stage load enable.
REQ-014 bsr_mode_o  output  1  boundary cells drive update-stage value.

Function
REQ-015 SHALL implement the 16-state IEEE 1149.1 TAP FSM (TEST_LOGIC_RESET, RUN_TEST_IDLE, SELECT/CAPTURE/SHIFT/EXIT1/PAUSE/EXIT2/UPDATE for DR and IR) with standard TMS-driven transitions.
REQ-016 Five consecutive tms_i=1 cycles SHALL reach TEST_LOGIC_RESET from any state.
REQ-017 Instructions (IR_W=4): EXTEST=0000, SAMPLE_PRELOAD=0001, IDCODE=0010, BYPASS=all ones; any other code SHALL behave as BYPASS.
REQ-018 Instruction shift register: CAPTURE_IR loads {0..0,01}; SHIFT_IR shifts right, tdi_i into MSB, LSB to tdo_o.
REQ-019 Active instruction register SHALL load from shift register only on posedge tck in UPDATE_IR; unchanged in all other states.
REQ-020 Entering TEST_LOGIC_RESET SHALL set active instruction to IDCODE.
REQ-021 DR selection from active instruction: EXTEST/SAMPLE_PRELOAD -> boundary chain; IDCODE -> 32-bit ID register; BYPASS -> 1-bit bypass register.
REQ-022 ID register: CAPTURE_DR (IDCODE selected) loads IDCODE; SHIFT_DR shifts right, tdi_i into bit 31, bit 0 to tdo_o.
REQ-023 Bypass register: CAPTURE_DR loads 0; SHIFT_DR loads tdi_i; tdo_o = bypass bit.
REQ-024 Boundary selected: bsr_shift_o=1 in SHIFT_DR; bsr_capture_o=1 in CAPTURE_DR or SHIFT_DR; bsr_update_o=1 in UPDATE_DR; all 0 otherwise and when boundary not selected.
REQ-025 bsr_mode_o SHALL be 1 iff active instruction is EXTEST, independent of FSM state.
REQ-026 Boundary controls SHALL decode combinationally from current state register (no added latency), so chain acts on same posedge the FSM leaves that state.
REQ-027 tdo_o: SHIFT_IR -> IR shift LSB; SHIFT_DR -> selected DR serial out (bsr_scan_i for boundary); 0 otherwise; tdo_en_o per REQ-008.
REQ-028 PAUSE_DR / PAUSE_IR SHALL hold all shift register contents.
REQ-029 Capture/shift/update affect only the selected DR; non-selected registers hold.

Reset
REQ-030 rst=1 SHALL immediately force state TEST_LOGIC_RESET, active instruction IDCODE, IR shift register {0..0,01}, bypass 0, ID register IDCODE.
REQ-031 During and after reset: tdo_o=0, tdo_en_o=0, bsr_shift_o=bsr_capture_o=bsr_update_o=0, bsr_mode_o=0.
REQ-032 rst asserted mid-shift SHALL abort; no UPDATE_IR/UPDATE_DR side effect occurs.

Verification
REQ-033 Reset, tms_i=0 then tms 1,0,0 to SHIFT_DR, shift 32 bits -> tdo_o sequence equals IDCODE LSB first.
REQ-034 Shift IR with tdi 1,1,1,1 then UPDATE_IR; shift DR 1,0,1 -> tdo_o 0,1,0 (one-cycle bypass delay).
REQ-035 Load EXTEST (0000) -> bsr_mode_o=1 after UPDATE_IR; in SHIFT_DR bsr_shift_o=bsr_capture_o=1, tdo_o follows bsr_scan_i; UPDATE_DR pulses bsr_update_o one cycle.
REQ-036 From SHIFT_IR, tms_i=1 five cycles -> TEST_LOGIC_RESET, active instruction IDCODE, bsr_mode_o=0.
REQ-037 CAPTURE_IR then SHIFT_IR 4 cycles with tdi 0 -> tdo_o 1,0,0,0.
REQ-038 Assert rst during SHIFT_DR with EXTEST active -> all bsr controls 0 at once, bsr_mode_o=0, no bsr_update_o pulse.

Source files
------------

// File: rtl/jtag_tap.sv
// IEEE 1149.1 test access port: 16-state TAP controller, instruction register,
// 32-bit ID register, bypass register and control of an external boundary chain.
// TMS and TDI are sampled on every posedge tck. There is no valid/ready
// handshake: each tck edge is one bit of transfer.
// state_o exposes the TAP state using the IEEE 1149.1 reference state encoding.
module jtag_tap #(
  parameter int          IR_W   = 4,
  parameter logic [31:0] IDCODE = 32'h1000_0001
) (
  input  logic       tck,
  input  logic       rst,
  input  logic       tms_i,
  input  logic       tdi_i,
  output logic       tdo_o,
  output logic       tdo_en_o,
  output logic       bsr_scan_o,
  input  logic       bsr_scan_i,
  output logic       bsr_shift_o,
  output logic       bsr_capture_o,
  output logic       bsr_update_o,
  output logic       bsr_mode_o,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET = 4'hF,
    RUN_TEST_IDLE    = 4'hC,
    SELECT_DR        = 4'h7,
    CAPTURE_DR       = 4'h6,
    SHIFT_DR         = 4'h2,
    EXIT1_DR         = 4'h1,
    PAUSE_DR         = 4'h3,
    EXIT2_DR         = 4'h0,
    UPDATE_DR        = 4'h5,
    SELECT_IR        = 4'h4,
    CAPTURE_IR       = 4'hE,
    SHIFT_IR         = 4'hA,
    EXIT1_IR         = 4'h9,
    PAUSE_IR         = 4'hB,
    EXIT2_IR         = 4'h8,
    UPDATE_IR        = 4'hD
  } tap_state_e;

  // Instruction codes; any code not listed here selects the bypass register.
  localparam logic [IR_W-1:0] IR_EXTEST  = '0;
  localparam logic [IR_W-1:0] IR_SAMPLE  = IR_W'(1);
  localparam logic [IR_W-1:0] IR_IDCODE  = IR_W'(2);
  localparam logic [IR_W-1:0] IR_CAPTURE = IR_W'(1);

  tap_state_e      state_q, state_d;
  logic [IR_W-1:0] ir_sr_q;   // instruction shift register
  logic [IR_W-1:0] ir_q;      // active instruction
  logic [31:0]     idr_q;     // ID register
  logic            byp_q;     // bypass register

  logic sel_bsr, sel_id, sel_byp;

  // Standard TMS-driven TAP transitions.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TEST_LOGIC_RESET: state_d = tms_i ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    state_d = tms_i ? SELECT_DR        : RUN_TEST_IDLE;
      SELECT_DR:        state_d = tms_i ? SELECT_IR        : CAPTURE_DR;
      CAPTURE_DR:       state_d = tms_i ? EXIT1_DR         : SHIFT_DR;
      SHIFT_DR:         state_d = tms_i ? EXIT1_DR         : SHIFT_DR;
      EXIT1_DR:         state_d = tms_i ? UPDATE_DR        : PAUSE_DR;
      PAUSE_DR:         state_d = tms_i ? EXIT2_DR         : PAUSE_DR;
      EXIT2_DR:         state_d = tms_i ? UPDATE_DR        : SHIFT_DR;
      UPDATE_DR:        state_d = tms_i ? SELECT_DR        : RUN_TEST_IDLE;
      SELECT_IR:        state_d = tms_i ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       state_d = tms_i ? EXIT1_IR         : SHIFT_IR;
      SHIFT_IR:         state_d = tms_i ? EXIT1_IR         : SHIFT_IR;
      EXIT1_IR:         state_d = tms_i ? UPDATE_IR        : PAUSE_IR;
      PAUSE_IR:         state_d = tms_i ? EXIT2_IR         : PAUSE_IR;
      EXIT2_IR:         state_d = tms_i ? UPDATE_IR        : SHIFT_IR;
      UPDATE_IR:        state_d = tms_i ? SELECT_DR        : RUN_TEST_IDLE;
      default:          state_d = TEST_LOGIC_RESET;
    endcase
  end

  // TAP state register; reset forces TEST_LOGIC_RESET immediately.
  always_ff @(posedge tck or posedge rst) begin
    if (rst) state_q <= TEST_LOGIC_RESET;
    else     state_q <= state_d;
  end

  // Instruction shift register and active instruction.
  // The active instruction reverts to IDCODE on any entry to TEST_LOGIC_RESET.
  always_ff @(posedge tck or posedge rst) begin
    if (rst) begin
      ir_sr_q <= IR_CAPTURE;
      ir_q    <= IR_IDCODE;
    end else begin
      if (state_q == CAPTURE_IR)    ir_sr_q <= IR_CAPTURE;
      else if (state_q == SHIFT_IR) ir_sr_q <= {tdi_i, ir_sr_q[IR_W-1:1]};
      if (state_d == TEST_LOGIC_RESET) ir_q <= IR_IDCODE;
      else if (state_q == UPDATE_IR)   ir_q <= ir_sr_q;
    end
  end

  // Data register selection from the active instruction.
  always_comb begin
    sel_bsr = (ir_q == IR_EXTEST) || (ir_q == IR_SAMPLE);
    sel_id  = (ir_q == IR_IDCODE);
    sel_byp = !sel_bsr && !sel_id;
  end

  // ID and bypass registers; only the selected one captures or shifts.
  always_ff @(posedge tck or posedge rst) begin
    if (rst) begin
      idr_q <= IDCODE;
      byp_q <= 1'b0;
    end else if (state_q == CAPTURE_DR) begin
      if (sel_id)  idr_q <= IDCODE;
      if (sel_byp) byp_q <= 1'b0;
    end else if (state_q == SHIFT_DR) begin
      if (sel_id)  idr_q <= {tdi_i, idr_q[31:1]};
      if (sel_byp) byp_q <= tdi_i;
    end
  end

  // Boundary controls decode straight from state_q so the chain acts on the
  // same edge the FSM leaves the state; capture stays high through shift.
  always_comb begin
    bsr_scan_o    = tdi_i;
    bsr_shift_o   = sel_bsr && (state_q == SHIFT_DR);
    bsr_capture_o = sel_bsr && ((state_q == CAPTURE_DR) || (state_q == SHIFT_DR));
    bsr_update_o  = sel_bsr && (state_q == UPDATE_DR);
    bsr_mode_o    = (ir_q == IR_EXTEST);
  end

  // Serial output mux; TDO is driven only while shifting.
  always_comb begin
    tdo_o    = 1'b0;
    tdo_en_o = (state_q == SHIFT_DR) || (state_q == SHIFT_IR);
    if (state_q == SHIFT_IR) begin
      tdo_o = ir_sr_q[0];
    end else if (state_q == SHIFT_DR) begin
      if (sel_bsr)     tdo_o = bsr_scan_i;
      else if (sel_id) tdo_o = idr_q[0];
      else             tdo_o = byp_q;
    end
  end

  assign state_o = state_q;

endmodule
